// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute stage of the multicycle MIPS datapath. Takes the 3-bit AluControl
//   code from the ALU decoder together with two operands and produces a
//   registered result.
//
//   Single-cycle ops : add, sub, and, or, slt (result one edge after accept)
//   Iterative op     : unsigned multiply (shift-add, one multiplier bit per
//                      cycle, result WIDTH edges after accept)
//   Illegal codes    : 100 and 101 produce a zero result with Illegal set.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     AluControl/srcA/srcB valid
//   in_ready     unit can accept an op this cycle
//   AluControl   010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mulu
//   srcA, srcB   operands
//   out_valid    result registers hold a result
//   out_ready    consumer takes the result this cycle
//   AluResult    result (mulu: low word of product)
//   AluResultHi  mulu: high word of product, 0 for other ops
//   Zero         AluResult == 0, registered with the result
//   Illegal      op was an illegal code

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       AluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AluResult,
  output logic [WIDTH-1:0] AluResultHi,
  output logic             Zero,
  output logic             Illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t               state_q,     state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q,    result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 zero_q,      zero_d;
  logic                 illegal_q,   illegal_d;
  logic [2*WIDTH-1:0]   mcand_q,     mcand_d;
  logic [WIDTH-1:0]     mplier_q,    mplier_d;
  logic [2*WIDTH-1:0]   acc_q,       acc_d;
  logic [CW-1:0]        count_q,     count_d;

  logic                 accept;
  logic [WIDTH-1:0]     single_res;
  logic                 single_illegal;
  logic [2*WIDTH-1:0]   mul_sum;

  // The unit only takes a new op from IDLE, and only when the result slot is
  // empty or being drained this very cycle; in_valid plays no part here.
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign AluResult   = result_q;
  assign AluResultHi = result_hi_q;
  assign Zero        = zero_q;
  assign Illegal     = illegal_q;

  // Single-cycle datapath: every legal non-multiply op is evaluated in
  // parallel from the live operands; the illegal codes give a zero result.
  always_comb begin
    single_res     = '0;
    single_illegal = 1'b0;
    case (AluControl)
      OP_ADD:  single_res = srcA + srcB;
      OP_SUB:  single_res = srcA - srcB;
      OP_AND:  single_res = srcA & srcB;
      OP_OR:   single_res = srcA | srcB;
      OP_SLT:  single_res = ($signed(srcA) < $signed(srcB)) ?
                            {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      OP_MULU: single_res = '0;
      default: single_illegal = 1'b1;
    endcase
  end

  // Shift-add step: the multiplicand is kept pre-shifted to the current
  // multiplier bit, so the partial product is a plain 2*WIDTH add.
  always_comb begin
    mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state logic for the FSM and every result/multiplier register. A
  // consumed result always clears out_valid; a new single-cycle accept in the
  // same cycle sets it again, which gives one op per clock when streaming.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (AluControl == OP_MULU) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, srcA};
            mplier_d = srcB;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
          end else begin
            out_valid_d = 1'b1;
            result_d    = single_res;
            result_hi_d = '0;
            zero_d      = (single_res == '0);
            illegal_d   = single_illegal;
          end
        end
      end
      MUL: begin
        acc_d    = mul_sum;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_sum[WIDTH-1:0];
          result_hi_d = mul_sum[2*WIDTH-1:WIDTH];
          zero_d      = (mul_sum[WIDTH-1:0] == '0);
          illegal_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, including a multiply in
  // progress or a result waiting to be taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Directed bench for alu_exec_unit. Expected results come from a behavioural
//   model and are queued when an op is accepted, then popped and compared
//   when the unit hands a result to the consumer.

module tb_alu_exec_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zero;
    logic         illegal;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   AluControl;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] AluResult;
  logic [W-1:0] AluResultHi;
  logic         Zero;
  logic         Illegal;

  exp_t sbQueue[$];
  int   errors;
  int   checks;
  int   cycle;
  int   prevPopCycle;
  bit   streamMode;
  bit   lastAccept;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AluControl  (AluControl),
    .srcA        (srcA),
    .srcB        (srcB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .AluResult   (AluResult),
    .AluResultHi (AluResultHi),
    .Zero        (Zero),
    .Illegal     (Illegal)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the unit's arithmetic.
  function automatic exp_t model(logic [2:0] ctl, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e = '0;
    case (ctl)
      3'b010: e.lo = a + b;
      3'b110: e.lo = a - b;
      3'b000: e.lo = a & b;
      3'b001: e.lo = a | b;
      3'b111: e.lo = ($signed(a) < $signed(b)) ? 1 : 0;
      3'b011: begin
        p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
      end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.lo == '0);
    return e;
  endfunction

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock. At the falling edge the handshakes that the next
  // rising edge will complete are recorded: a consumed result is popped and
  // compared, an accepted op pushes its expected result.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    lastAccept = 1'b0;
    if (!reset) begin
      if (out_valid && out_ready) begin
        checkOutput("sb_nonempty", 64'(sbQueue.size() != 0), 64'd1);
        if (sbQueue.size() != 0) begin
          e = sbQueue.pop_front();
          checkOutput("res_lo",      64'(AluResult),   64'(e.lo));
          checkOutput("res_hi",      64'(AluResultHi), 64'(e.hi));
          checkOutput("res_zero",    64'(Zero),        64'(e.zero));
          checkOutput("res_illegal", 64'(Illegal),     64'(e.illegal));
        end
        if (streamMode && prevPopCycle >= 0) begin
          checkOutput("stream_gap", 64'(cycle - prevPopCycle), 64'd1);
        end
        prevPopCycle = cycle;
      end
      if (in_valid && in_ready) begin
        sbQueue.push_back(model(AluControl, srcA, srcB));
        lastAccept = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Present one op and hold it until the unit accepts it (bounded wait).
  task automatic applyStimulus(logic [2:0] ctl, logic [W-1:0] a, logic [W-1:0] b);
    int n;
    in_valid   = 1'b1;
    AluControl = ctl;
    srcA       = a;
    srcB       = b;
    n          = 0;
    lastAccept = 1'b0;
    while (!lastAccept && n < 200) begin
      tick();
      n++;
    end
    checkOutput("accept_timeout", 64'(lastAccept), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    cycle        = 0;
    prevPopCycle = -1;
    streamMode   = 1'b0;
    lastAccept   = 1'b0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    AluControl   = 3'b000;
    srcA         = '0;
    srcB         = '0;

    $display("[TB] reset");
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(out_valid),   64'd0);
    checkOutput("rst_result",    64'(AluResult),   64'd0);
    checkOutput("rst_result_hi", 64'(AluResultHi), 64'd0);
    checkOutput("rst_zero",      64'(Zero),        64'd0);
    checkOutput("rst_illegal",   64'(Illegal),     64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),    64'd1);
    reset = 1'b0;
    tick();

    $display("[TB] T1 add overflow");
    out_ready = 1'b1;
    applyStimulus(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    checkOutput("t1_latency", 64'(out_valid), 64'd1);
    checkOutput("t1_result",  64'(AluResult), 64'h8000_0000);
    tick();

    $display("[TB] T2 sub and slt");
    applyStimulus(3'b110, 32'd5, 32'd5);
    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(3'b111, 32'd1, 32'hFFFF_FFFF);
    tick();
    checkOutput("t2_drained", 64'(sbQueue.size()), 64'd0);

    $display("[TB] T3 mulu");
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < W; k++) begin
      checkOutput("t3_busy_ready", 64'(in_ready),  64'd0);
      checkOutput("t3_busy_valid", 64'(out_valid), 64'd0);
      tick();
    end
    checkOutput("t3_valid_edge", 64'(out_valid),   64'd1);
    checkOutput("t3_hi",         64'(AluResultHi), 64'hFFFF_FFFE);
    checkOutput("t3_lo",         64'(AluResult),   64'h0000_0001);
    tick();
    applyStimulus(3'b011, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (W + 1) tick();
    checkOutput("t3_drained", 64'(sbQueue.size()), 64'd0);

    $display("[TB] T4 backpressure");
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    in_valid   = 1'b1;
    AluControl = 3'b001;
    srcA       = 32'h0000_F0F0;
    srcB       = 32'h0000_FF00;
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t4_hold_res",   64'(AluResult), 64'h0000_F000);
      checkOutput("t4_hold_zero",  64'(Zero),      64'd0);
      checkOutput("t4_in_ready",   64'(in_ready),  64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("t4_or_valid", 64'(out_valid), 64'd1);
    checkOutput("t4_or_res",   64'(AluResult), 64'h0000_FFF0);
    tick();

    $display("[TB] T5 illegal and stream");
    applyStimulus(3'b100, 32'h1234_5678, 32'h1111_1111);
    checkOutput("t5_illegal", 64'(Illegal),   64'd1);
    checkOutput("t5_zero",    64'(Zero),      64'd1);
    checkOutput("t5_result",  64'(AluResult), 64'd0);
    applyStimulus(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    streamMode   = 1'b1;
    prevPopCycle = -1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'b010, $urandom, $urandom);
    end
    tick();
    streamMode = 1'b0;
    checkOutput("t5_drained", 64'(sbQueue.size()), 64'd0);

    $display("[TB] T6 reset during mulu");
    applyStimulus(3'b011, 32'h0000_00FF, 32'h0000_0F0F);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    sbQueue.delete();
    checkOutput("t6_out_valid", 64'(out_valid),   64'd0);
    checkOutput("t6_result",    64'(AluResult),   64'd0);
    checkOutput("t6_result_hi", 64'(AluResultHi), 64'd0);
    checkOutput("t6_zero",      64'(Zero),        64'd0);
    checkOutput("t6_illegal",   64'(Illegal),     64'd0);
    checkOutput("t6_in_ready",  64'(in_ready),    64'd1);
    reset = 1'b0;
    applyStimulus(3'b010, 32'd40, 32'd2);
    checkOutput("t6_add_valid", 64'(out_valid), 64'd1);
    checkOutput("t6_add_res",   64'(AluResult), 64'd42);
    repeat (W + 2) tick();
    checkOutput("t6_no_stray",  64'(out_valid),       64'd0);
    checkOutput("t6_drained",   64'(sbQueue.size()),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
